// File: rtl/ext_arbiter.sv
// Two-requester immediate-extension unit with one shared result register.
// Build option: define EXT_ARB_SHIFT_EN to enable the branch-offset mode.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req0/req1          request lines, operands held until granted
//   imm0/imm1          16-bit immediates
//   mode0/mode1        extension mode (0 zext, 1 high half, 2 sext, 3 offset)
//   gnt0/gnt1          combinational grants
//   out_valid/out_ready  result handshake
//   out_id             requester that owns the result
//   out_value          32-bit extended immediate
module ext_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] imm0,
    input  logic [15:0] imm1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_id,
    output logic [31:0] out_value
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [31:0] value_q, value_d;

    logic        accept;
    logic        pick0, pick1;
    logic        any_gnt;
    logic [15:0] sel_imm;
    logic [1:0]  sel_mode;
    logic [31:0] ext_val;

    function automatic logic [31:0] extend(
        input logic [15:0] imm,
        input logic [1:0]  mode
    );
        logic [31:0] sext;
        logic [31:0] res;
        sext = {{16{imm[15]}}, imm};
        res  = 32'h0;
        case (mode)
            2'd0: res = {16'h0, imm};
            2'd1: res = {imm, 16'h0};
            2'd2: res = sext;
            2'd3: begin
`ifdef EXT_ARB_SHIFT_EN
                res = {sext[29:0], 2'b00};
`else
                res = 32'h0;
`endif
            end
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // A new result may be written when the register is empty or is
    // being drained in this same cycle.
    assign accept = (state_q == EMPTY) || out_ready;

    // last_q = 1 means requester 1 was granted last, so 0 wins a tie.
    assign pick0 = req0 && (!req1 || last_q);
    assign pick1 = req1 && (!req0 || !last_q);

    assign gnt0    = !rst && accept && pick0;
    assign gnt1    = !rst && accept && pick1;
    assign any_gnt = gnt0 || gnt1;

    assign sel_imm  = gnt1 ? imm1  : imm0;
    assign sel_mode = gnt1 ? mode1 : mode0;
    assign ext_val  = extend(sel_imm, sel_mode);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        value_d = value_q;

        case (state_q)
            EMPTY: begin
                if (any_gnt) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (any_gnt) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (any_gnt) begin
            value_d = ext_val;
            id_d    = gnt1;
            last_d  = gnt1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            value_q <= 32'h0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            value_q <= value_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_id    = id_q;
    assign out_value = value_q;

endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 The block SHALL have the ports req0 and req1, input, 1 bit each: requester n wants an extension; held high with its operands stable until granted.
REQ-004 The block SHALL have the ports imm0 and imm1, input, 16 bits each: immediate field of requester n.
REQ-005 The block SHALL have the ports mode0 and mode1, input, 2 bits each: 0 = zero-extend high half, 1 = value in high half with low half zero, 2 = sign-extend, 3 = see REQ-020.
REQ-006 The block SHALL have the ports gnt0 and gnt1, output, 1 bit each: combinational grant; a request is accepted in the cycle req and gnt are both high.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: the consumer takes the result in any cycle out_valid and out_ready are both high.
REQ-009 The block SHALL have the port out_id, output, 1 bit: index of the requester that owns the result.
REQ-010 The block SHALL have the port out_value, output, 32 bits: the extended immediate.

Function
REQ-011 The block SHALL share one extension datapath and one result register between the two requesters.
REQ-012 The block SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 Transitions SHALL be: EMPTY -> FULL on a grant; FULL -> EMPTY on a drain with no grant in the same cycle; FULL -> FULL on a drain plus a grant in the same cycle; FULL -> FULL on no drain.
REQ-014 A grant SHALL be possible only when out_valid=0, or when out_valid=1 and out_ready=1 (drain and refill in the same cycle).
REQ-015 At most one of gnt0/gnt1 SHALL be high in any cycle, and gnt n SHALL never be high while req n is low.
REQ-016 With one requester active and acceptance possible, that requester SHALL be granted.
REQ-017 With both requesters active, the requester not granted last SHALL be granted (round-robin); the last-granted pointer SHALL update only on a grant.
REQ-018 Latency SHALL be one cycle: out_value/out_id/out_valid SHALL reflect the operands granted at edge k starting after edge k.
REQ-019 out_value and out_id SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Mode 3 SHALL produce 32'h0000_0000 unless REQ-028 applies.
REQ-021 Sustained throughput SHALL be one result per cycle when out_ready is held high.

Reset
REQ-022 On rst high, out_valid SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-023 On rst high, out_value SHALL clear to 32'h0 and out_id to 0.
REQ-024 On rst high, the last-granted pointer SHALL be set to 1, so that req0 wins the first contention.
REQ-025 While rst is high, gnt0 and gnt1 SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending result; requesters keep req high and are re-arbitrated after reset releases.

Configuration
REQ-027 The macro EXT_ARB_SHIFT_EN SHALL control the branch-offset mode.
REQ-028 With EXT_ARB_SHIFT_EN defined, mode 3 SHALL produce {sign-extend(imm)[29:0], 2'b00}, i.e. the sign-extended immediate shifted left by 2.
REQ-029 Without EXT_ARB_SHIFT_EN, mode 3 SHALL behave per REQ-020 and no shifter logic SHALL be synthesized.

Verification
REQ-030 Single request: req0=1, imm0=16'h8001, mode0=2, out_ready=1 -> gnt0=1 in that cycle; next cycle out_valid=1, out_id=0, out_value=32'hFFFF8001.
REQ-031 Modes 0 and 1: req1=1, imm1=16'h1234, mode1=0 then mode1=1 -> out_value 32'h00001234, then 32'h12340000, with out_id=1 for both.
REQ-032 Contention: after reset, req0 and req1 both held high with out_ready=1 -> grants alternate 0,1,0,1 over four cycles and out_id follows one cycle later.
REQ-033 Backpressure: the result is FULL and out_ready=0 for 3 cycles while req1=1 -> gnt1=0 and out_value is stable for those cycles; when out_ready rises -> gnt1=1 in that same cycle and the new result follows next cycle.
REQ-034 Mode 3: imm0=16'hFFFF, mode0=3 -> 32'hFFFFFFFC with EXT_ARB_SHIFT_EN defined; 32'h00000000 without it.
REQ-035 Reset mid-operation: rst pulsed asynchronously between edges while out_valid=1 -> out_valid=0 immediately; after release, req0 wins the first contention.
